// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit register file, code decode,
// anti-ghost blanking, 16-level brightness. Per-digit blink is built only with SEG_SCAN_BLINK_EN.
module seg_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int ADDR_W         = 3,
  parameter int W_CODE         = 5,
  parameter int SCAN_CYC       = 15000,
  parameter int BLANK_CYC      = 10,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W_CODE-1:0] wr_code,
  input  logic              wr_dp,
  input  logic              wr_blink,
  input  logic [3:0]        bright,
  output logic [7:0]        segment,
  output logic [DIGITS-1:0] seg_sel,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(SCAN_CYC);
  localparam int IDX_W = $clog2(DIGITS);
  localparam int STEP  = (SCAN_CYC - BLANK_CYC) / 15;

  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0]  LATCH_CNT = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]  BLANK_CNT = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  LAST_DIG  = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_INV   = {8{~SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};

  logic [W_CODE-1:0] code_q [DIGITS];
  logic [DIGITS-1:0] dp_q;

  logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]  dig_idx_q, dig_idx_d;
  logic [3:0]        bright_q, bright_d;
  logic [7:0]        segment_q;
  logic [DIGITS-1:0] seg_sel_q, seg_sel_d;
  logic              frame_done_q, frame_done_d;
  logic              slot_wrap, latch_now, suppress, sel_on;
  logic [31:0]       lim;
  logic [DIGITS-1:0] onehot;

  // Internal pattern is active-low {dp, g..a}; polarity applied on the way out.
  function automatic logic [7:0] decode(input logic [W_CODE-1:0] code, input logic dp);
    logic [6:0] s;
    s = 7'h7F;
    case (int'(code))
      0:  s = 7'h40;
      1:  s = 7'h79;
      2:  s = 7'h24;
      3:  s = 7'h30;
      4:  s = 7'h19;
      5:  s = 7'h12;
      6:  s = 7'h02;
      7:  s = 7'h78;
      8:  s = 7'h00;
      9:  s = 7'h10;
      16: s = 7'h23;
      17: s = 7'h0C;
      18: s = 7'h06;
      19: s = 7'h2B;
      20: s = 7'h47;
      21: s = 7'h46;
      22: s = 7'h05;
      23: s = 7'h21;
      24: s = 7'h2F;
      default: s = 7'h7F;
    endcase
    return {~dp, s} ^ SEG_INV;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) code_q[i] <= W_CODE'(5'h1F);
      dp_q <= '0;
    end else if (wr_en) begin
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          code_q[i] <= wr_code;
          dp_q[i]   <= wr_dp;
        end
      end
    end
  end

  always_comb begin
    slot_wrap    = (slot_cnt_q == LAST_SLOT);
    latch_now    = (slot_cnt_q == LATCH_CNT);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    dig_idx_d    = dig_idx_q;
    if (slot_wrap) dig_idx_d = (dig_idx_q == LAST_DIG) ? '0 : dig_idx_q + 1'b1;
    bright_d     = latch_now ? bright : bright_q;
    frame_done_d = slot_wrap && (dig_idx_q == LAST_DIG);
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [DIGITS-1:0] blink_q;
  logic [FR_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_ph_q, blink_ph_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_addr == ADDR_W'(i)) blink_q[i] <= wr_blink;
      end
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_done_q) begin
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    suppress = blink_q[dig_idx_d] && blink_ph_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = wr_blink;
  assign suppress     = 1'b0;
`endif

  // Select is computed from next-cycle counter values so it lines up with the registered pins.
  always_comb begin
    lim    = 32'(BLANK_CYC) + 32'(bright_d) * 32'(STEP);
    sel_on = (slot_cnt_d >= BLANK_CNT) &&
             ((bright_d == 4'hF) || (32'(slot_cnt_d) < lim)) && !suppress;
    onehot = '0;
    onehot[dig_idx_d] = 1'b1;
    seg_sel_d = sel_on ? (onehot ^ SEL_OFF) : SEL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      bright_q     <= '0;
      segment_q    <= 8'hFF ^ SEG_INV;
      seg_sel_q    <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      bright_q     <= bright_d;
      seg_sel_q    <= seg_sel_d;
      frame_done_q <= frame_done_d;
      if (latch_now) segment_q <= decode(code_q[dig_idx_q], dp_q[dig_idx_q]);
    end
  end

  assign segment    = segment_q;
  assign seg_sel    = seg_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed 7-segment scan controller for the lock front panel. It supersedes the fixed six-digit driver and holds a per-digit register file that is written one digit at a time. It decodes 5-bit display codes (digits plus lock-message letters) and drives a one-hot digit select. It adds three things the fixed driver lacked: anti-ghost blanking, 16-level brightness, and per-digit blink. It sits between the lock FSM (writer) and the board's segment/select pins.

## Interface
- DIGITS, 6, number of multiplexed digits (2..16)
- ADDR_W, 3, width of wr_addr; must satisfy 2^ADDR_W >= DIGITS
- W_CODE, 5, display code width (fixed decode table uses 5)
- SCAN_CYC, 15000, clk cycles per digit slot
- BLANK_CYC, 10, cycles at slot start with all selects off (1 <= BLANK_CYC < SCAN_CYC-15)
- BLINK_FRAMES, 64, full frames per blink half-period
- SEG_ACTIVE_LOW, 1, 1: segment bits active-low; 0: inverted
- SEL_ACTIVE_LOW, 1, 1: seg_sel active-low; 0: active-high
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  write strobe, one digit per cycle, always accepted
- wr_addr  in  ADDR_W  digit index
- wr_code  in  W_CODE  display code
- wr_dp  in  1  decimal point on for this digit
- wr_blink  in  1  blink enable for this digit
- bright  in  4  global brightness, 0 = dark, 15 = full
- segment  out  8  {dp, g..a}, registered
- seg_sel  out  DIGITS  digit select, registered
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot

## Operation
- Register file: per digit {code, dp, blink}. Reset value is code 5'h1F (blank), dp=0, blink=0. A write with wr_addr >= DIGITS is ignored.
- slot_cnt counts 0..SCAN_CYC-1. dig_idx advances on slot_cnt wrap and wraps DIGITS-1 -> 0.
- Decode, internal active-low g..a:
  - Digits 0-9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
  - Letters 0x10-0x18 = O P E N L C K D R: 0x23, 0x0C, 0x06, 0x2B, 0x47, 0x46, 0x05, 0x21, 0x2F.
  - Any other code: 0x7F (blank).
  - dp on drives internal bit7 = 0.
  - Output = internal value XOR {8{~SEG_ACTIVE_LOW}}.
- Segment latch: segment loads decode(reg[dig_idx]) when slot_cnt == BLANK_CYC-1. It holds for the rest of the slot, so a write mid-slot appears on that digit's next visit.
- Select: STEP = (SCAN_CYC-BLANK_CYC)/15 (localparam). The digit is on when all of the following hold:
  - slot_cnt >= BLANK_CYC;
  - bright == 15, or slot_cnt < BLANK_CYC + bright*STEP;
  - the digit is not blink-suppressed.
  - When on, the select is one-hot at dig_idx; otherwise all off. Polarity follows SEL_ACTIVE_LOW.
- bright is sampled once per slot, at slot_cnt == BLANK_CYC-1. bright == 0 keeps all selects off.
- Blink: frame_cnt counts frame_done pulses 0..BLINK_FRAMES-1. On wrap, blink_ph toggles. A digit with blink=1 is suppressed while blink_ph=1; its segment still latches normally.

## Timing
- Reset values:
  - segment = blank with dp off (0xFF if SEG_ACTIVE_LOW, else 0x00);
  - seg_sel = all inactive;
  - frame_done = 0;
  - slot_cnt = 0, dig_idx = 0, frame_cnt = 0, blink_ph = 0.
- Write-to-register latency is 1 cycle. Write-to-pin latency is bounded by one frame (DIGITS*SCAN_CYC) + 1.
- seg_sel and segment are registered and change together at slot_cnt == BLANK_CYC-1 (+1 clk). seg_sel drops to all-off at slot_cnt == 0 (+1 clk) of each slot.
- frame_done is asserted in the cycle after slot_cnt == SCAN_CYC-1 with dig_idx == DIGITS-1.
- Simultaneous write and latch to the same digit: the latch uses the old register value.
- Async reset mid-frame: all outputs return to reset values immediately. The scan restarts at digit 0.

## Configuration
- SEG_SCAN_BLINK_EN defined: the blink bit storage, frame_cnt, and blink_ph are present as described.
- SEG_SCAN_BLINK_EN undefined: wr_blink is ignored, no blink logic is synthesised, and no digit is ever suppressed. frame_done remains present.

## Test plan
All scenarios use DIGITS=4, SCAN_CYC=20, BLANK_CYC=4, BLINK_FRAMES=2, both polarities active-low.
- Reset: hold rst_n=0 -> segment=0xFF, seg_sel=4'b1111, frame_done=0. After release, digit 0 is selected at cycle 4 (+1) showing blank (0xFF).
- Write addr 0..3 with codes 1, 2, 0x10, 0x11 and bright=15 -> per slot: seg_sel 1110/1101/1011/0111 with segment 0xF9/0xA4/0xA3/0x8C. Selects are off for the first 4 cycles of each slot. frame_done fires every 80 cycles.
- bright=4 (STEP=1) -> each digit is selected for exactly 4 cycles per slot (slot_cnt 4..7). bright=0 -> seg_sel stays 1111.
- wr_dp=1 on digit 2 and code 0x1B (undefined) on digit 3 -> digit 2 segment bit7=0. Digit 3 shows 0xFF. A write to addr 5 leaves all digits unchanged.
- Blink on digit 1 -> digit 1 is selected in frames 0-1, dark in frames 2-3, then repeats. The other digits are unaffected. With the macro undefined, digit 1 is never dark.
- Write digit 0 while digit 0 is on (slot_cnt=10) -> old pattern is held until slot end. The new pattern appears on the next visit. Asserting rst_n=0 mid-slot returns all outputs to reset values in the same cycle.
